// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the writeback stage and a queued multi-cycle unit.
// Define RF_WRITE_ARBITER_BYPASS_EN to let an accepted result reach the port in the same cycle when the queue is empty.
module rf_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_we,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_wd,
    input  logic                     mc_valid,
    input  logic [ADDRESS_WIDTH-1:0] mc_rd,
    input  logic [DATA_WIDTH-1:0]    mc_wd,
    output logic                     mc_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DATA_WIDTH-1:0]    fwd1,
    output logic [DATA_WIDTH-1:0]    fwd2,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0]    rf_wd,
    output logic                     stall_req
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDRESS_WIDTH-1:0] rd_q [DEPTH];
    logic [DATA_WIDTH-1:0]    wd_q [DEPTH];
    logic [DEPTH-1:0]         live_q;
    logic [PTR_W-1:0]         head_q;
    logic [PTR_W-1:0]         tail_q;
    logic [CNT_W-1:0]         count_q;
    logic [STV_W-1:0]         starve_q;
    logic                     stall_q;

    logic wb_act;
    logic empty;
    logic head_live;
    logic accept;
    logic bypass;
    logic enq;
    logic pop;

    assign wb_act    = wb_we && (wb_rd != '0);
    assign empty     = (count_q == '0);
    assign head_live = !empty && live_q[head_q];
    assign mc_ready  = rst_n && (count_q < CNT_W'(DEPTH));
    assign accept    = mc_valid && mc_ready;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    assign bypass    = empty && !wb_act && accept && (mc_rd != '0);
`else
    assign bypass    = 1'b0;
`endif
    // x0 results are accepted but dropped; bypassed results never occupy a slot
    assign enq       = accept && (mc_rd != '0) && !bypass;
    assign pop       = !empty && (!live_q[head_q] || !wb_act);
    assign stall_req = stall_q;

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (!rst_n) begin
            rf_we = 1'b0;
        end else if (wb_act) begin
            rf_we = 1'b1;
            rf_a3 = wb_rd;
            rf_wd = wb_wd;
        end else if (head_live) begin
            rf_we = 1'b1;
            rf_a3 = rd_q[head_q];
            rf_wd = wd_q[head_q];
        end else if (bypass) begin
            rf_we = 1'b1;
            rf_a3 = mc_rd;
            rf_wd = mc_wd;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        if (rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (live_q[head_q + PTR_W'(k)] && (rd_q[head_q + PTR_W'(k)] == rs1) && (rs1 != '0)) begin
                    hit1 = 1'b1;
                    fwd1 = wd_q[head_q + PTR_W'(k)];
                end
                if (live_q[head_q + PTR_W'(k)] && (rd_q[head_q + PTR_W'(k)] == rs2) && (rs2 != '0)) begin
                    hit2 = 1'b1;
                    fwd2 = wd_q[head_q + PTR_W'(k)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[tail_q] <= mc_rd;
            wd_q[tail_q] <= mc_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            live_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_act && (rd_q[i] == wb_rd)) begin
                    live_q[i] <= 1'b0;
                end
            end
            // Freed slots are marked dead so the lookup only ever sees occupied entries
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            // A concurrent writeback to the same register is younger, so the entry arrives dead
            if (enq) begin
                live_q[tail_q] <= !(wb_act && (mc_rd == wb_rd));
                tail_q         <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);

            if (empty || pop) begin
                starve_q <= '0;
                stall_q  <= 1'b0;
            end else if (head_live && wb_act) begin
                if (starve_q < STV_W'(STARVE_LIMIT)) begin
                    starve_q <= starve_q + STV_W'(1);
                end
                if (starve_q >= STV_W'(STARVE_LIMIT - 1)) begin
                    stall_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SL    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_wd;
    logic          mc_valid;
    logic [AW-1:0] mc_rd;
    logic [DW-1:0] mc_wd;
    logic          mc_ready;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic          rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic          stall_req;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wd(mc_wd), .mc_ready(mc_ready),
        .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .stall_req(stall_req)
    );

    // Reference model: an in-order list of pending results plus a blocked-cycle tally
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
        bit            live;
    } ent_t;

    ent_t q[$];
    int   blocked = 0;
    bit   stall_m = 1'b0;

    logic          e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    logic          e_ready;
    logic          e_hit1;
    logic          e_hit2;
    logic [DW-1:0] e_fwd1;
    logic [DW-1:0] e_fwd2;

    function automatic bit model_bypass();
`ifdef RF_WRITE_ARBITER_BYPASS_EN
        return (q.size() == 0) && !(wb_we && wb_rd != 0) && mc_valid && (mc_rd != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_eval();
        e_we = 0; e_a3 = 0; e_wd = 0; e_ready = 0;
        e_hit1 = 0; e_hit2 = 0; e_fwd1 = 0; e_fwd2 = 0;
        if (rst_n) begin
            e_ready = (q.size() < DEPTH);
            if (wb_we && wb_rd != 0) begin
                e_we = 1; e_a3 = wb_rd; e_wd = wb_wd;
            end else if (q.size() > 0 && q[0].live) begin
                e_we = 1; e_a3 = q[0].rd; e_wd = q[0].wd;
            end else if (model_bypass()) begin
                e_we = 1; e_a3 = mc_rd; e_wd = mc_wd;
            end
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!e_hit1 && q[i].live && q[i].rd == rs1 && rs1 != 0) begin
                    e_hit1 = 1; e_fwd1 = q[i].wd;
                end
                if (!e_hit2 && q[i].live && q[i].rd == rs2 && rs2 != 0) begin
                    e_hit2 = 1; e_fwd2 = q[i].wd;
                end
            end
        end
    endfunction

    function automatic void model_clock();
        bit   act;
        bit   was_empty;
        bit   acc;
        bit   byp;
        bit   popped;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            blocked = 0;
            stall_m = 0;
            return;
        end
        act       = wb_we && (wb_rd != 0);
        was_empty = (q.size() == 0);
        acc       = mc_valid && (q.size() < DEPTH);
        byp       = model_bypass();
        popped    = !was_empty && (!q[0].live || !act);
        if (act) begin
            foreach (q[i]) if (q[i].rd == wb_rd) q[i].live = 0;
        end
        if (popped) void'(q.pop_front());
        if (acc && mc_rd != 0 && !byp) begin
            e.rd = mc_rd; e.wd = mc_wd; e.live = !(act && mc_rd == wb_rd);
            q.push_back(e);
        end
        if (was_empty || popped) begin
            blocked = 0;
            stall_m = 0;
        end else begin
            blocked++;
            if (blocked >= SL) stall_m = 1;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_rd = 0; wb_wd = 0;
        mc_valid = 0; mc_rd = 0; mc_wd = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; wb_we = 1; wb_rd = 5; wb_wd = 32'h1234;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we: got %0h want 0", rf_we); end
            n_checks++;
            if (mc_ready !== 1'b0) begin n_errors++; $display("FAIL reset_mc_ready: got %0h want 0", mc_ready); end
            n_checks++;
            if (rf_a3 !== 5'd0 || hit1 !== 1'b0 || fwd1 !== 32'd0) begin
                n_errors++; $display("FAIL reset_outputs: a3=%0h hit1=%0h fwd1=%0h want 0", rf_a3, hit1, fwd1);
            end
            cycle();
        end
        rst_n = 1; wb_we = 0; wb_rd = 0;
        @(negedge clk);
        n_checks++;
        if (mc_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_mc_ready: got %0h want 1", mc_ready); end
        n_checks++;
        if (stall_req !== 1'b0) begin n_errors++; $display("FAIL post_reset_stall: got %0h want 0", stall_req); end
        cycle();
    endtask

    task automatic test_idle_drain();
        idle_inputs();
        mc_valid = 1; mc_rd = 7; mc_wd = 32'hDEAD;
        @(negedge clk);
`ifdef RF_WRITE_ARBITER_BYPASS_EN
        n_checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || rf_wd !== 32'hDEAD) begin
            n_errors++; $display("FAIL drain_bypass: we=%0h a3=%0h wd=%0h want 1/7/dead", rf_we, rf_a3, rf_wd);
        end
`else
        n_checks++;
        if (rf_we !== 1'b0) begin n_errors++; $display("FAIL drain_accept_cycle: we=%0h want 0", rf_we); end
`endif
        cycle();
        mc_valid = 0;
        @(negedge clk);
`ifdef RF_WRITE_ARBITER_BYPASS_EN
        n_checks++;
        if (rf_we !== 1'b0) begin n_errors++; $display("FAIL drain_after_bypass: we=%0h want 0", rf_we); end
`else
        n_checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || rf_wd !== 32'hDEAD) begin
            n_errors++; $display("FAIL drain_write: we=%0h a3=%0h wd=%0h want 1/7/dead", rf_we, rf_a3, rf_wd);
        end
`endif
        cycle();
        rs1 = 7;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0 || hit1 !== 1'b0) begin
            n_errors++; $display("FAIL drain_empty: we=%0h hit1=%0h want 0/0", rf_we, hit1);
        end
        cycle();
    endtask

    task automatic test_priority_fwd();
        idle_inputs();
        wb_we = 1; wb_rd = 9; wb_wd = 32'h99;
        mc_valid = 1; mc_rd = 3; mc_wd = 32'h11; rs1 = 3; rs2 = 3;
        @(negedge clk);
        n_checks++;
        if (rf_a3 !== 5'd9 || hit1 !== 1'b0) begin
            n_errors++; $display("FAIL prio_first: a3=%0h hit1=%0h want 9/0", rf_a3, hit1);
        end
        cycle();
        mc_valid = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (rf_we !== 1'b1 || rf_a3 !== 5'd9 || rf_wd !== 32'h99) begin
                n_errors++; $display("FAIL prio_wb: we=%0h a3=%0h wd=%0h want 1/9/99", rf_we, rf_a3, rf_wd);
            end
            n_checks++;
            if (hit1 !== 1'b1 || fwd1 !== 32'h11 || hit2 !== 1'b1 || fwd2 !== 32'h11) begin
                n_errors++; $display("FAIL prio_fwd: hit1=%0h fwd1=%0h hit2=%0h fwd2=%0h want 1/11", hit1, fwd1, hit2, fwd2);
            end
            cycle();
        end
        wb_we = 0;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd3 || rf_wd !== 32'h11) begin
            n_errors++; $display("FAIL prio_drain: we=%0h a3=%0h wd=%0h want 1/3/11", rf_we, rf_a3, rf_wd);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0 || hit1 !== 1'b0) begin
            n_errors++; $display("FAIL prio_empty: we=%0h hit1=%0h want 0/0", rf_we, hit1);
        end
        cycle();
    endtask

    task automatic test_waw_kill();
        idle_inputs();
        wb_we = 1; wb_rd = 9; wb_wd = 32'h99;
        mc_valid = 1; mc_rd = 4; mc_wd = 32'hAA;
        cycle();
        mc_valid = 0; wb_rd = 4; wb_wd = 32'hBB; rs1 = 4;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd4 || rf_wd !== 32'hBB) begin
            n_errors++; $display("FAIL waw_wb: we=%0h a3=%0h wd=%0h want 1/4/bb", rf_we, rf_a3, rf_wd);
        end
        n_checks++;
        if (hit1 !== 1'b1 || fwd1 !== 32'hAA) begin
            n_errors++; $display("FAIL waw_hit_before: hit1=%0h fwd1=%0h want 1/aa", hit1, fwd1);
        end
        cycle();
        wb_we = 0;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0 || hit1 !== 1'b0 || fwd1 !== 32'd0) begin
            n_errors++; $display("FAIL waw_killed_pop: we=%0h hit1=%0h fwd1=%0h want 0/0/0", rf_we, hit1, fwd1);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0 || mc_ready !== 1'b1) begin
            n_errors++; $display("FAIL waw_empty: we=%0h ready=%0h want 0/1", rf_we, mc_ready);
        end
        cycle();
    endtask

    task automatic test_full_x0();
        idle_inputs();
        wb_we = 1; wb_rd = 9; wb_wd = 32'h99;
        for (int i = 0; i < DEPTH; i++) begin
            mc_valid = 1; mc_rd = AW'(10 + i); mc_wd = 32'h100 + i;
            @(negedge clk);
            n_checks++;
            if (mc_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready[%0d]: got %0h want 1", i, mc_ready); end
            cycle();
        end
        mc_rd = 14; mc_wd = 32'h114;
        @(negedge clk);
        n_checks++;
        if (mc_ready !== 1'b0 || rf_a3 !== 5'd9) begin
            n_errors++; $display("FAIL full_ready: ready=%0h a3=%0h want 0/9", mc_ready, rf_a3);
        end
        cycle();
        mc_valid = 0; wb_we = 0;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd10) begin
            n_errors++; $display("FAIL full_first_drain: we=%0h a3=%0h want 1/a", rf_we, rf_a3);
        end
        cycle();
        wb_we = 1; mc_valid = 1; mc_rd = 0; mc_wd = 32'h55;
        @(negedge clk);
        n_checks++;
        if (mc_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready: got %0h want 1", mc_ready); end
        cycle();
        mc_valid = 0;
        @(negedge clk);
        n_checks++;
        if (mc_ready !== 1'b1) begin n_errors++; $display("FAIL x0_not_enqueued: ready=%0h want 1", mc_ready); end
        cycle();
        wb_we = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(negedge clk);
            n_checks++;
            if (rf_we !== 1'b1 || rf_a3 !== AW'(11 + i) || rf_wd !== 32'h101 + i) begin
                n_errors++; $display("FAIL full_drain[%0d]: we=%0h a3=%0h wd=%0h", i, rf_we, rf_a3, rf_wd);
            end
            cycle();
        end
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) begin n_errors++; $display("FAIL full_drained: we=%0h a3=%0h want 0", rf_we, rf_a3); end
        cycle();
    endtask

    task automatic test_starvation();
        idle_inputs();
        wb_we = 1; wb_rd = 9; wb_wd = 32'h99;
        mc_valid = 1; mc_rd = 6; mc_wd = 32'h66;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_req !== 1'b0) begin n_errors++; $display("FAIL starve_early[%0d]: got %0h want 0", c, stall_req); end
            cycle();
            mc_valid = 0;
        end
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b1) begin n_errors++; $display("FAIL starve_assert: got %0h want 1", stall_req); end
        cycle();
        wb_we = 0;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b1 || rf_we !== 1'b1 || rf_a3 !== 5'd6 || rf_wd !== 32'h66) begin
            n_errors++; $display("FAIL starve_drain: stall=%0h we=%0h a3=%0h wd=%0h want 1/1/6/66", stall_req, rf_we, rf_a3, rf_wd);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0 || rf_we !== 1'b0) begin
            n_errors++; $display("FAIL starve_release: stall=%0h we=%0h want 0/0", stall_req, rf_we);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            wb_we    = ($urandom_range(0, 9) < 6);
            wb_rd    = AW'($urandom_range(0, 7));
            wb_wd    = $urandom;
            mc_valid = $urandom_range(0, 1);
            mc_rd    = AW'($urandom_range(0, 7));
            mc_wd    = $urandom;
            rs1      = AW'($urandom_range(0, 7));
            rs2      = AW'($urandom_range(0, 7));
            @(negedge clk);
            model_eval();
            n_checks++;
            if (rf_we !== e_we || rf_a3 !== e_a3 || rf_wd !== e_wd) begin
                n_errors++; $display("FAIL rand_port[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", c, rf_we, rf_a3, rf_wd, e_we, e_a3, e_wd);
            end
            n_checks++;
            if (mc_ready !== e_ready) begin
                n_errors++; $display("FAIL rand_ready[%0d]: got %0h want %0h", c, mc_ready, e_ready);
            end
            n_checks++;
            if (hit1 !== e_hit1 || fwd1 !== e_fwd1) begin
                n_errors++; $display("FAIL rand_fwd1[%0d]: got %0h/%0h want %0h/%0h", c, hit1, fwd1, e_hit1, e_fwd1);
            end
            n_checks++;
            if (hit2 !== e_hit2 || fwd2 !== e_fwd2) begin
                n_errors++; $display("FAIL rand_fwd2[%0d]: got %0h/%0h want %0h/%0h", c, hit2, fwd2, e_hit2, e_fwd2);
            end
            n_checks++;
            if (stall_req !== stall_m) begin
                n_errors++; $display("FAIL rand_stall[%0d]: got %0h want %0h", c, stall_req, stall_m);
            end
            cycle();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_idle_drain();
        test_priority_fwd();
        test_waw_kill();
        test_full_x0();
        test_starvation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
